// File: rtl/perf_event_monitor_if.sv
// Control, event and readout signals of the performance monitor.
// The CPU side (master) drives the strobes and the monitor (slave) returns the counters.
interface perf_event_monitor_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned PC_W    = 32
);
    logic               start_i;
    logic               clear_i;
    logic               en_i;
    logic [NUM_EVT-1:0] evt_i;
    logic [PC_W-1:0]    pc_i;
    logic [3:0]         sel_i;
    logic [CNT_W-1:0]   rd_data_o;
    logic [CNT_W-1:0]   cycle_o;
    logic [PC_W-1:0]    last_pc_o;
    logic [NUM_EVT:0]   sat_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, clear_i, en_i, evt_i, pc_i, sel_i,
        input  rd_data_o, cycle_o, last_pc_o, sat_o, busy_o, done_o
    );

    modport slave (
        input  start_i, clear_i, en_i, evt_i, pc_i, sel_i,
        output rd_data_o, cycle_o, last_pc_o, sat_o, busy_o, done_o
    );
endinterface

// File: rtl/perf_event_monitor.sv
// Per-core cycle/event counters with a run/stop FSM, cycle budget, saturating counts,
// capture of the PC of the latest event 0 and a registered indexed read port.
module perf_event_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NUM_EVT    = 4,
    parameter int unsigned MAX_CYCLES = 64,
    parameter int unsigned PC_W       = 32
) (
    input logic                 clk_i,
    input logic                 rst_i,
    perf_event_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CycLimit = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                         state_q, state_d;
    logic                           count;
    logic [CNT_W-1:0]               cyc_q, cyc_d, cyc_inc;
    logic [NUM_EVT-1:0][CNT_W-1:0]  evt_q, evt_d;
    logic [PC_W-1:0]                pc_q, pc_d;
    logic [NUM_EVT:0]               sat_q, sat_d;
    logic [CNT_W-1:0]               rd_q, rd_d;

    assign cyc_inc = (cyc_q == CntMax) ? cyc_q : cyc_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        count   = 1'b0;
        case (state_q)
            StIdle: if (mon.start_i) state_d = StRun;
            StRun: begin
                if (mon.en_i) begin
                    count = 1'b1;
                    // Budget is checked against the post-increment count so the last cycle counts.
                    if (MAX_CYCLES != 0 && cyc_inc == CycLimit) state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (mon.clear_i) begin
            state_d = StIdle;
            count   = 1'b0;
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        evt_d = evt_q;
        pc_d  = pc_q;
        sat_d = sat_q;
        if (mon.clear_i) begin
            cyc_d = '0;
            evt_d = '0;
            pc_d  = '0;
            sat_d = '0;
        end else begin
            if (count) begin
                cyc_d = cyc_inc;
                for (int k = 0; k < int'(NUM_EVT); k++) begin
                    if (mon.evt_i[k] && evt_q[k] != CntMax) evt_d[k] = evt_q[k] + CNT_W'(1);
                end
                if (mon.evt_i[0]) pc_d = mon.pc_i;
            end
            sat_d[0] = sat_q[0] | (cyc_d == CntMax);
            for (int k = 0; k < int'(NUM_EVT); k++) begin
                sat_d[k+1] = sat_q[k+1] | (evt_d[k] == CntMax);
            end
        end
    end

    // Read port samples the pre-update counters; out-of-range indices read zero.
    always_comb begin
        rd_d = '0;
        if (mon.sel_i == 4'd0) rd_d = cyc_q;
        for (int k = 0; k < int'(NUM_EVT); k++) begin
            if (mon.sel_i == 4'(k + 1)) rd_d = evt_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            evt_q   <= '0;
            pc_q    <= '0;
            sat_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            evt_q   <= evt_d;
            pc_q    <= pc_d;
            sat_q   <= sat_d;
            rd_q    <= rd_d;
        end
    end

    assign mon.rd_data_o = rd_q;
    assign mon.cycle_o   = cyc_q;
    assign mon.last_pc_o = pc_q;
    assign mon.sat_o     = sat_q;
    assign mon.busy_o    = (state_q == StRun);
    assign mon.done_o    = (state_q == StDone);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a 32-bit/64-cycle-budget instance and a 4-bit/unlimited
// instance share one stimulus stream and are compared every cycle against a reference model.
module tb_perf_event_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clear = 1'b0, en = 1'b0;
    logic [3:0]  evt = '0;
    logic [31:0] pc = '0;
    logic [3:0]  sel = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    perf_event_monitor_if #(.CNT_W(32), .NUM_EVT(4), .PC_W(32)) ifa ();
    perf_event_monitor_if #(.CNT_W(4),  .NUM_EVT(4), .PC_W(32)) ifb ();

    assign ifa.start_i = start;  assign ifb.start_i = start;
    assign ifa.clear_i = clear;  assign ifb.clear_i = clear;
    assign ifa.en_i    = en;     assign ifb.en_i    = en;
    assign ifa.evt_i   = evt;    assign ifb.evt_i   = evt;
    assign ifa.pc_i    = pc;     assign ifb.pc_i    = pc;
    assign ifa.sel_i   = sel;    assign ifb.sel_i   = sel;

    perf_event_monitor #(.CNT_W(32), .NUM_EVT(4), .MAX_CYCLES(64), .PC_W(32)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (ifa)
    );

    perf_event_monitor #(.CNT_W(4), .NUM_EVT(4), .MAX_CYCLES(0), .PC_W(32)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (ifb)
    );

    // Reference model: states 0 idle, 1 run, 2 done; saturating unsigned arithmetic.
    localparam longint unsigned CMAX [2] = '{64'hFFFF_FFFF, 64'd15};
    localparam longint unsigned LIMIT[2] = '{64'd64, 64'd0};

    int              mst [2];
    longint unsigned mcyc[2];
    longint unsigned mev [2][4];
    longint unsigned mpc [2];
    bit [4:0]        msat[2];
    longint unsigned mrd [2];

    function automatic longint unsigned sat_add(longint unsigned v, longint unsigned mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mst[m] = 0; mcyc[m] = 0; mpc[m] = 0; msat[m] = '0; mrd[m] = 0;
                for (int k = 0; k < 4; k++) mev[m][k] = 0;
            end else begin
                int s;
                s = int'(sel);
                if (s == 0)      mrd[m] = mcyc[m];
                else if (s <= 4) mrd[m] = mev[m][s-1];
                else             mrd[m] = 0;
                if (clear) begin
                    mst[m] = 0; mcyc[m] = 0; mpc[m] = 0; msat[m] = '0;
                    for (int k = 0; k < 4; k++) mev[m][k] = 0;
                end else if (mst[m] == 0) begin
                    if (start) mst[m] = 1;
                end else if (mst[m] == 1 && en) begin
                    mcyc[m] = sat_add(mcyc[m], CMAX[m]);
                    for (int k = 0; k < 4; k++) if (evt[k]) mev[m][k] = sat_add(mev[m][k], CMAX[m]);
                    if (evt[0]) mpc[m] = pc;
                    if (LIMIT[m] != 0 && mcyc[m] == LIMIT[m]) mst[m] = 2;
                end
                if (mcyc[m] == CMAX[m]) msat[m][0] = 1'b1;
                for (int k = 0; k < 4; k++) if (mev[m][k] == CMAX[m]) msat[m][k+1] = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.cycle", 64'(ifa.cycle_o), mcyc[0]);
            chk("a.busy", 64'(ifa.busy_o), 64'(mst[0] == 1));
            chk("a.done", 64'(ifa.done_o), 64'(mst[0] == 2));
            chk("a.last_pc", 64'(ifa.last_pc_o), mpc[0]);
            chk("a.sat", 64'(ifa.sat_o), 64'(msat[0]));
            chk("a.rd", 64'(ifa.rd_data_o), mrd[0]);
            chk("b.cycle", 64'(ifb.cycle_o), mcyc[1]);
            chk("b.busy", 64'(ifb.busy_o), 64'(mst[1] == 1));
            chk("b.done", 64'(ifb.done_o), 64'(mst[1] == 2));
            chk("b.last_pc", 64'(ifb.last_pc_o), mpc[1]);
            chk("b.sat", 64'(ifb.sat_o), 64'(msat[1]));
            chk("b.rd", 64'(ifb.rd_data_o), mrd[1]);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0]  t2_evt[7] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01};
    logic [31:0] t2_pc [7] = '{32'h0, 32'h0, 32'h10, 32'h0, 32'h24, 32'h3C, 32'h50};

    initial begin
        step(2);
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset.cycle", 64'(ifa.cycle_o), 64'd0);
        chk("reset.busy", 64'(ifa.busy_o), 64'd0);
        chk("reset.rd", 64'(ifa.rd_data_o), 64'd0);

        // Basic run to the 64-cycle budget.
        start = 1'b1; step(1); start = 1'b0;
        chk("t1.busy_after_start", 64'(ifa.busy_o), 64'd1);
        en = 1'b1;
        step(63);
        chk("t1.cycle63", 64'(ifa.cycle_o), 64'd63);
        step(1);
        chk("t1.cycle64", 64'(ifa.cycle_o), 64'd64);
        chk("t1.done", 64'(ifa.done_o), 64'd1);
        chk("t1.busy_fell", 64'(ifa.busy_o), 64'd0);
        step(6);
        chk("t1.cycle_hold", 64'(ifa.cycle_o), 64'd64);
        en = 1'b0; clear = 1'b1; step(1); clear = 1'b0;
        chk("t1.cleared", 64'(ifa.cycle_o), 64'd0);

        // Event counting and PC capture; last entry is with en low.
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en  = (i < 6);
            evt = {2'b00, t2_evt[i]};
            pc  = t2_pc[i];
            step(1);
        end
        en = 1'b0; evt = '0; pc = '0;
        sel = 4'd2; step(1);
        chk("t2.evt1", 64'(ifa.rd_data_o), 64'd5);
        sel = 4'd1; step(1);
        chk("t2.evt0", 64'(ifa.rd_data_o), 64'd3);
        chk("t2.last_pc", 64'(ifa.last_pc_o), 64'h3C);
        chk("t2.cycle", 64'(ifa.cycle_o), 64'd6);

        // Event on the final budget cycle counts; events in DONE do not.
        en = 1'b1; step(57);
        evt = 4'b0100; step(1);
        chk("t3.done", 64'(ifa.done_o), 64'd1);
        step(3);
        evt = '0; sel = 4'd3; step(1);
        chk("t3.evt2", 64'(ifa.rd_data_o), 64'd1);
        chk("t3.cycle", 64'(ifa.cycle_o), 64'd64);

        // Clear and start together in DONE, then reset mid-run.
        clear = 1'b1; start = 1'b1; step(1); clear = 1'b0; start = 1'b0;
        chk("t5.busy", 64'(ifa.busy_o), 64'd0);
        chk("t5.done", 64'(ifa.done_o), 64'd0);
        chk("t5.cycle", 64'(ifa.cycle_o), 64'd0);
        step(1);
        chk("t5.evt2_zero", 64'(ifa.rd_data_o), 64'd0);
        start = 1'b1; step(1); start = 1'b0;
        step(10);
        chk("t5.cycle10", 64'(ifa.cycle_o), 64'd10);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("t5.rst_cycle", 64'(ifa.cycle_o), 64'd0);
        chk("t5.rst_done", 64'(ifa.done_o), 64'd0);
        chk("t5.rst_rd", 64'(ifa.rd_data_o), 64'd0);

        // Saturation on the 4-bit unlimited instance.
        en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        en = 1'b1; evt = 4'b0001; step(20);
        en = 1'b0; evt = '0;
        chk("t4.b_cycle", 64'(ifb.cycle_o), 64'd15);
        chk("t4.b_sat", 64'(ifb.sat_o), 64'b00011);
        chk("t4.b_busy", 64'(ifb.busy_o), 64'd1);
        chk("t4.a_cycle", 64'(ifa.cycle_o), 64'd20);
        sel = 4'd1; step(1);
        chk("t4.b_evt0", 64'(ifb.rd_data_o), 64'd15);
        chk("t4.a_evt0", 64'(ifa.rd_data_o), 64'd20);

        // Read-port range.
        sel = 4'd5; step(1);
        chk("t6.sel5", 64'(ifa.rd_data_o), 64'd0);
        sel = 4'd15; step(1);
        chk("t6.sel15", 64'(ifa.rd_data_o), 64'd0);
        sel = 4'd0; en = 1'b1; step(1);
        chk("t6.sel0_prior", 64'(ifa.rd_data_o), 64'd20);
        chk("t6.cycle21", 64'(ifa.cycle_o), 64'd21);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(199) == 0);
            clear = ($urandom_range(39) == 0);
            start = ($urandom_range(7) == 0);
            en    = ($urandom_range(3) != 0);
            evt   = 4'($urandom);
            pc    = $urandom;
            sel   = 4'($urandom);
            step(1);
        end
        rst = 1'b0; clear = 1'b0; start = 1'b0; en = 1'b0;
        step(1);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perf_event_monitor.md
Name: perf_event_monitor

Overview:
- Synthesizable per-core performance and trace monitor for the pipelined RISC-V CPU.
- Counts cycles and NUM_EVT pipeline events under a run/stop state machine. Typical events: branch resolved, mispredict, IF/ID flush, load-use stall.
- Stops automatically after a programmable cycle budget, captures the PC of the most recent event 0, and exposes every counter through a registered indexed read port.
- Sits beside the CPU top and is fed by ID/EX and hazard-unit signals.

Parameters:
CNT_W, 32, width of every counter (cycle and event).
NUM_EVT, 4, number of event inputs/counters (1..15).
MAX_CYCLES, 64, cycle budget that ends a run; 0 = unlimited.
PC_W, 32, width of captured PC.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_i  in  1  synchronous reset, active-high.
start_i  in  1  pulse: begin a run (accepted in IDLE only).
clear_i  in  1  pulse: zero counters, return to IDLE.
en_i  in  1  count enable (pause when low during RUN).
evt_i  in  NUM_EVT  per-cycle event strobes, bit k -> counter k.
pc_i  in  PC_W  PC associated with evt_i[0].
sel_i  in  4  read index: 0 = cycle counter, k = event counter k-1.
rd_data_o  out  CNT_W  registered read data.
cycle_o  out  CNT_W  live cycle counter.
last_pc_o  out  PC_W  pc_i at most recent counted evt_i[0].
sat_o  out  NUM_EVT+1  sticky saturation flags; bit 0 = cycle, bit k = event k-1.
busy_o  out  1  high in RUN.
done_o  out  1  high in DONE.

Behaviour:
- Reset (rst_i=1 at edge):
  - state=IDLE.
  - All counters, last_pc_o, sat_o and rd_data_o = 0.
  - busy_o=0, done_o=0.
- Priority at each edge: rst_i > clear_i > start_i > counting.
- States:
  - IDLE: counters hold. start_i=1 -> RUN; no counting in the accepting cycle.
  - RUN: each cycle with en_i=1:
    - cycle counter +1.
    - each counter k with evt_i[k]=1 increments.
    - evt_i[0]=1 loads pc_i into last_pc_o.
    - With en_i=0, nothing changes, including last_pc_o.
    - If MAX_CYCLES != 0 and the incremented cycle count equals MAX_CYCLES, go to DONE at that same edge. Events in that final cycle are counted.
  - DONE: everything frozen; start_i ignored. clear_i -> IDLE.
  - clear_i in any state: zero counters, sat_o and last_pc_o; state=IDLE. clear_i and start_i together -> IDLE only; start is dropped.
- Saturation:
  - A counter at all-ones stays at all-ones and sets its sat_o bit.
  - sat_o is sticky until clear_i or rst_i.
  - Arithmetic is unsigned with no wrap-around.
- Read port:
  - rd_data_o <= value selected by sel_i, sampled at the edge and showing pre-update counter values. Latency is 1 cycle.
  - Read is valid in any state.
  - sel_i > NUM_EVT -> rd_data_o = 0.
- busy_o and done_o are decoded directly from the state register. They change on the edge that changes state.
- MAX_CYCLES=0: RUN persists until clear_i or rst_i; the cycle counter saturates.
- rst_i asserted mid-run: at that edge all state returns to the reset values; no partial counts survive.

Test Plan:
1. Basic run:
   - Stimulus: reset; start_i pulse; en_i=1 and evt_i=0 for 70 cycles with MAX_CYCLES=64.
   - Required: done_o rises at the edge where cycle_o becomes 64; cycle_o stays 64; busy_o falls on the same edge.
2. Event counting and PC capture:
   - Stimulus: in RUN, evt_i[1] on 5 cycles; evt_i[0] on 3 cycles with pc_i=0x10, 0x24, 0x3C; en_i low on one evt_i[0] cycle with pc_i=0x50.
   - Required: sel_i=2 -> rd_data_o=5 one cycle later; sel_i=1 -> 3; last_pc_o=0x3C.
3. Boundary cycle:
   - Stimulus: evt_i[2]=1 during the 64th counting cycle; then evt_i[2]=1 in DONE.
   - Required: counter 2 = 1; no further change in DONE.
4. Saturation:
   - Stimulus: CNT_W=4; evt_i[0]=1 for 20 counting cycles, MAX_CYCLES=0.
   - Required: counter 0 = 15; sat_o[1]=1; cycle counter saturates at 15 with sat_o[0]=1 after 15 cycles; state stays RUN.
5. Clear/start collision and mid-run reset:
   - Stimulus: assert clear_i and start_i together in DONE.
   - Required: state IDLE, counters 0, busy_o=0.
   - Stimulus: start, count 10 cycles, then rst_i.
   - Required: cycle_o=0, done_o=0, rd_data_o=0.
6. Read-port range:
   - Stimulus: sel_i=NUM_EVT+1 and sel_i=15.
   - Required: rd_data_o=0 one cycle later; sel_i=0 returns cycle_o as sampled at the prior edge.
